// File: rtl/rkey_loader.sv
// AES round-key loader: streams NR+1 round keys from the expander onto
// the broadcast rkey/addr bus and gates data-block launch until all are resident.
// Ports: clk, rst (async high), key_start, kx_rkey/kx_valid/kx_ready (key stream),
//        rkey/addr (broadcast), busy, keys_ready, dp_req/dp_gnt (launch gate).
module rkey_loader #(
  parameter int          NR        = 10,
  parameter logic [3:0]  IDLE_ADDR = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_start,
  input  logic [127:0] kx_rkey,
  input  logic         kx_valid,
  output logic         kx_ready,
  output logic [127:0] rkey,
  output logic [3:0]   addr,
  output logic         busy,
  output logic         keys_ready,
  input  logic         dp_req,
  output logic         dp_gnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_READY
  } state_e;

  localparam logic [3:0] LAST = 4'(NR);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   addr_q, addr_d;
  logic         rdy_q, rdy_d;
  logic         accept;

  // key_start masks ready so an abort never consumes the beat on the bus
  assign kx_ready   = (state_q == S_LOAD) && !key_start;
  assign accept     = kx_valid && kx_ready;
  assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign keys_ready = rdy_q;
  assign dp_gnt     = dp_req && rdy_q;
  assign rkey       = rkey_q;
  assign addr       = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    rkey_d  = rkey_q;
    addr_d  = IDLE_ADDR;

    // park the address on idle cycles so no stage rewrites its key
    if (accept) begin
      rkey_d = kx_rkey;
      addr_d = cnt_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (key_start) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
        end
      end
      S_LOAD: begin
        if (key_start) begin
          cnt_d = 4'd0;
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // last key is captured by stage NR on this edge
        if (key_start) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_READY;
          rdy_d   = 1'b1;
        end
      end
      S_READY: begin
        if (key_start) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
          rdy_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rkey_q  <= '0;
      addr_q  <= IDLE_ADDR;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rkey_q  <= rkey_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_rkey_loader.sv
// Testbench for rkey_loader: directed key loads with a write scoreboard
// and a model of the add_rkey stages fed by the broadcast bus.
module tb_rkey_loader;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_start;
  logic [127:0] kx_rkey;
  logic         kx_valid;
  logic         kx_ready;
  logic [127:0] rkey;
  logic [3:0]   addr;
  logic         busy;
  logic         keys_ready;
  logic         dp_req;
  logic         dp_gnt;

  rkey_loader #(.NR(NR), .IDLE_ADDR(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .kx_rkey    (kx_rkey),
    .kx_valid   (kx_valid),
    .kx_ready   (kx_ready),
    .rkey       (rkey),
    .addr       (addr),
    .busy       (busy),
    .keys_ready (keys_ready),
    .dp_req     (dp_req),
    .dp_gnt     (dp_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   a;
    logic [127:0] k;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  logic         mon_en = 1'b0;
  logic         exp_ready = 1'b0;
  logic         exp_busy = 1'b0;
  logic [127:0] stage [0:15];

  function automatic logic [127:0] kv(int i, logic [31:0] salt);
    logic [31:0] w;
    w = 32'(i) + salt;
    return {4{w}};
  endfunction

  // add_rkey stage model: stage i latches when the broadcast addr is i
  always @(posedge clk) begin
    if (!rst && addr != 4'hF) stage[addr] <= rkey;
  end

  // monitor: status flags every cycle, writes popped from the scoreboard
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: got %b want %b t=%0t", busy, exp_busy, $time);
      end
      checks++;
      if (keys_ready !== exp_ready) begin
        errors++;
        $display("FAIL keys_ready: got %b want %b t=%0t",
                 keys_ready, exp_ready, $time);
      end
      checks++;
      if (dp_gnt !== (dp_req && exp_ready)) begin
        errors++;
        $display("FAIL dp_gnt: got %b want %b t=%0t",
                 dp_gnt, dp_req && exp_ready, $time);
      end
      if (addr !== 4'hF) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h rkey=%h t=%0t",
                   addr, rkey, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (addr !== e.a || rkey !== e.k) begin
            errors++;
            $display("FAIL write: got addr=%h rkey=%h want addr=%h rkey=%h",
                     addr, rkey, e.a, e.k);
          end
        end
      end
    end
  end

  task automatic start();
    key_start = 1'b1;
    @(posedge clk);
    #1;
    key_start = 1'b0;
    exp_ready = 1'b0;
    exp_busy  = 1'b1;
  endtask

  task automatic beat(int i, logic [31:0] salt);
    bit done;
    done = 0;
    q.push_back('{a: 4'(i), k: kv(i, salt)});
    kx_rkey  = kv(i, salt);
    kx_valid = 1'b1;
    checks++;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (kx_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    kx_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout: beat %0d got no ready want ready", i);
    end
  endtask

  task automatic finish_load();
    kx_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
  endtask

  task automatic check_stages(logic [31:0] salt, string tag);
    for (int i = 0; i <= NR; i++) begin
      checks++;
      if (stage[i] !== kv(i, salt)) begin
        errors++;
        $display("FAIL stage_%s[%0d]: got %h want %h",
                 tag, i, stage[i], kv(i, salt));
      end
    end
  endtask

  task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    key_start = 1'b0;
    kx_rkey   = '0;
    kx_valid  = 1'b0;
    dp_req    = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", 128'(addr), 128'hF);
    chk("rst_rkey", rkey, '0);
    chk("rst_busy", 128'(busy), '0);
    chk("rst_keys_ready", 128'(keys_ready), '0);
    chk("rst_kx_ready", 128'(kx_ready), '0);
    chk("rst_dp_gnt", 128'(dp_gnt), '0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // back-to-back load; keys_ready one edge after addr=10
    start();
    for (int i = 0; i <= NR; i++) beat(i, 32'h0);
    finish_load();
    check_stages(32'h0, "b2b");

    // kx_valid low every other cycle
    start();
    for (int i = 0; i <= NR; i++) begin
      beat(i, 32'h1000_0000);
      if (i < NR) begin
        @(posedge clk);
        #1;
      end
    end
    finish_load();
    check_stages(32'h1000_0000, "gap");

    // abort after 5 accepts, then full reload
    start();
    for (int i = 0; i < 5; i++) beat(i, 32'hA5A5_0000);
    start();
    for (int i = 0; i <= NR; i++) beat(i, 32'h0B00_0000);
    finish_load();
    check_stages(32'h0B00_0000, "abort");

    // key_start with a valid beat: beat is held, then written to addr 0
    key_start = 1'b1;
    kx_valid  = 1'b1;
    kx_rkey   = kv(0, 32'h5500_0000);
    @(negedge clk);
    chk("start_kx_ready", 128'(kx_ready), '0);
    @(posedge clk);
    #1;
    key_start = 1'b0;
    exp_ready = 1'b0;
    exp_busy  = 1'b1;
    for (int i = 0; i <= NR; i++) beat(i, 32'h5500_0000);
    finish_load();
    check_stages(32'h5500_0000, "collide");

    // no request, no grant
    dp_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dp_req = 1'b1;
    @(posedge clk);
    #1;

    // asynchronous reset mid-load with cnt=4
    start();
    for (int i = 0; i < 4; i++) beat(i, 32'h7700_0000);
    kx_rkey  = kv(4, 32'h7700_0000);
    kx_valid = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr", 128'(addr), 128'hF);
    chk("arst_rkey", rkey, '0);
    chk("arst_busy", 128'(busy), '0);
    chk("arst_keys_ready", 128'(keys_ready), '0);
    chk("arst_kx_ready", 128'(kx_ready), '0);
    kx_valid  = 1'b0;
    exp_busy  = 1'b0;
    exp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", 128'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
